// File: rtl/prco_regfile_pkg.sv
// -----------------------------------------------------------------------------
// prco_constants
//   Shared PRCO pipeline constants: default register-file geometry, the
//   stack/base-pointer register indices and their reset value, plus a small
//   helper for range-checking register selects when NREGS is not a power of 2.
// -----------------------------------------------------------------------------
package prco_constants;

  localparam int unsigned PRCO_DATA_W    = 16;
  localparam int unsigned PRCO_NREGS     = 8;
  localparam int unsigned REG_SP         = 6;
  localparam int unsigned REG_BP         = 7;
  localparam logic [15:0] PRCO_STACK_RST = 16'h00FF;

  // True when a select addresses a physically present register.
  function automatic logic sel_ok(input int unsigned sel, input int unsigned nregs);
    return sel < nregs;
  endfunction

endpackage

// File: rtl/prco_regfile_rdport.sv
// -----------------------------------------------------------------------------
// prco_regfile_rdport
//   One registered read port of the PRCO register file. Chooses between the
//   pre-write and post-write views of the storage and scoreboard (BYPASS),
//   forces zero/not-busy for selects beyond NREGS, and registers the result.
//
//   i_clk, i_reset, i_en : clock, sync active-high reset, block enable
//   i_sel                : register select
//   i_regs / i_regs_nxt  : storage before / after this edge's writes
//   i_busy / i_busy_nxt  : scoreboard before / after this edge's updates
//   q_data, q_busy       : registered read data and busy flag
// -----------------------------------------------------------------------------
module prco_regfile_rdport
  import prco_constants::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned AW     = 3,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_en,
  input  logic [AW-1:0]                  i_sel,
  input  logic [NREGS-1:0][DATA_W-1:0]   i_regs,
  input  logic [NREGS-1:0][DATA_W-1:0]   i_regs_nxt,
  input  logic [NREGS-1:0]               i_busy,
  input  logic [NREGS-1:0]               i_busy_nxt,
  output logic [DATA_W-1:0]              q_data,
  output logic                           q_busy
);

  logic                         w_ok;
  logic [NREGS-1:0][DATA_W-1:0] w_src_regs;
  logic [NREGS-1:0]             w_src_busy;
  logic [DATA_W-1:0]            w_data;
  logic                         w_busy;

  // Write-first sees the post-update view so a same-cycle producer is
  // forwarded; read-first sees the state as it stood before the edge.
  assign w_src_regs = BYPASS ? i_regs_nxt : i_regs;
  assign w_src_busy = BYPASS ? i_busy_nxt : i_busy;
  assign w_ok       = sel_ok(32'(i_sel), NREGS);

  always_comb begin
    w_data = '0;
    w_busy = 1'b0;
    if (w_ok) begin
      w_data = w_src_regs[i_sel];
      w_busy = w_src_busy[i_sel];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q_data <= '0;
      q_busy <= 1'b0;
    end else if (i_en) begin
      q_data <= w_data;
      q_busy <= w_busy;
    end
  end

endmodule

// File: rtl/prco_regfile.sv
// -----------------------------------------------------------------------------
// prco_regfile
//   PRCO register set: NREGS x DATA_W storage, two write ports (ALU = port A,
//   load = port B), two registered read ports, and a per-register busy
//   scoreboard that decode uses to spot pending-writeback hazards.
//
//   i_clk, i_reset, i_en          : clock, sync active-high reset, enable
//   i_sela -> q_data, q_busya     : read port A
//   i_selb -> q_datb, q_busyb     : read port B
//   i_we, i_seld, i_datd          : write port A (wins on same-register collision)
//   i_we2, i_seld2, i_datd2       : write port B
//   i_claim, i_selc               : mark a register as pending writeback
// -----------------------------------------------------------------------------
module prco_regfile
  import prco_constants::*;
#(
  parameter int unsigned        DATA_W    = PRCO_DATA_W,
  parameter int unsigned        NREGS     = PRCO_NREGS,
  parameter int unsigned        SP_IDX    = REG_SP,
  parameter int unsigned        BP_IDX    = REG_BP,
  parameter logic [DATA_W-1:0]  STACK_RST = DATA_W'(PRCO_STACK_RST),
  parameter bit                 BYPASS    = 1'b1,
  localparam int unsigned       AW        = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [AW-1:0]     i_sela,
  output logic [DATA_W-1:0] q_data,
  output logic              q_busya,
  input  logic [AW-1:0]     i_selb,
  output logic [DATA_W-1:0] q_datb,
  output logic              q_busyb,
  input  logic              i_we,
  input  logic [AW-1:0]     i_seld,
  input  logic [DATA_W-1:0] i_datd,
  input  logic              i_we2,
  input  logic [AW-1:0]     i_seld2,
  input  logic [DATA_W-1:0] i_datd2,
  input  logic              i_claim,
  input  logic [AW-1:0]     i_selc
);

  logic [NREGS-1:0][DATA_W-1:0] r_regs;
  logic [NREGS-1:0]             r_busy;
  logic [NREGS-1:0][DATA_W-1:0] w_regs_nxt;
  logic [NREGS-1:0]             w_busy_nxt;
  logic                         w_wr_a, w_wr_b, w_clm;

  // Out-of-range destinations are dropped here so nothing downstream
  // needs to care about non-power-of-two NREGS.
  assign w_wr_a = i_en & i_we    & sel_ok(32'(i_seld),  NREGS);
  assign w_wr_b = i_en & i_we2   & sel_ok(32'(i_seld2), NREGS);
  assign w_clm  = i_en & i_claim & sel_ok(32'(i_selc),  NREGS);

  // Next-state view. Port B is applied before port A so A wins a collision;
  // the claim is applied last because it names a newer producer than any
  // write landing in the same cycle.
  always_comb begin
    w_regs_nxt = r_regs;
    w_busy_nxt = r_busy;
    if (w_wr_b) begin
      w_regs_nxt[i_seld2] = i_datd2;
      w_busy_nxt[i_seld2] = 1'b0;
    end
    if (w_wr_a) begin
      w_regs_nxt[i_seld] = i_datd;
      w_busy_nxt[i_seld] = 1'b0;
    end
    if (w_clm) begin
      w_busy_nxt[i_selc] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= (i == int'(SP_IDX) || i == int'(BP_IDX)) ? STACK_RST : '0;
      end
      r_busy <= '0;
    end else if (i_en) begin
      r_regs <= w_regs_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  prco_regfile_rdport #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rd_a (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (i_en),
    .i_sel      (i_sela),
    .i_regs     (r_regs),
    .i_regs_nxt (w_regs_nxt),
    .i_busy     (r_busy),
    .i_busy_nxt (w_busy_nxt),
    .q_data     (q_data),
    .q_busy     (q_busya)
  );

  prco_regfile_rdport #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rd_b (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (i_en),
    .i_sel      (i_selb),
    .i_regs     (r_regs),
    .i_regs_nxt (w_regs_nxt),
    .i_busy     (r_busy),
    .i_busy_nxt (w_busy_nxt),
    .q_data     (q_datb),
    .q_busy     (q_busyb)
  );

endmodule

// File: tb/tb_prco_regfile.sv
// Three register files share one stimulus stream:
//   0: defaults, write-first      1: defaults, read-first
//   2: 32-bit, 6 registers, SP=4/BP=5, reset 0000FFFF, write-first
module tb_prco_regfile;

  logic        clk = 1'b0;
  logic        rst, en, we, we2, claim;
  logic [2:0]  sela, selb, seld, seld2, selc;
  logic [31:0] d, d2;

  logic [15:0] a_qd, a_qb, b_qd, b_qb;
  logic [31:0] c_qd, c_qb;
  logic        a_ba, a_bb, b_ba, b_bb, c_ba, c_bb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prco_regfile #(.BYPASS(1'b1)) u_a (
    .i_clk(clk), .i_reset(rst), .i_en(en),
    .i_sela(sela), .q_data(a_qd), .q_busya(a_ba),
    .i_selb(selb), .q_datb(a_qb), .q_busyb(a_bb),
    .i_we(we), .i_seld(seld), .i_datd(d[15:0]),
    .i_we2(we2), .i_seld2(seld2), .i_datd2(d2[15:0]),
    .i_claim(claim), .i_selc(selc));

  prco_regfile #(.BYPASS(1'b0)) u_b (
    .i_clk(clk), .i_reset(rst), .i_en(en),
    .i_sela(sela), .q_data(b_qd), .q_busya(b_ba),
    .i_selb(selb), .q_datb(b_qb), .q_busyb(b_bb),
    .i_we(we), .i_seld(seld), .i_datd(d[15:0]),
    .i_we2(we2), .i_seld2(seld2), .i_datd2(d2[15:0]),
    .i_claim(claim), .i_selc(selc));

  prco_regfile #(.DATA_W(32), .NREGS(6), .SP_IDX(4), .BP_IDX(5),
                 .STACK_RST(32'h0000_FFFF), .BYPASS(1'b1)) u_c (
    .i_clk(clk), .i_reset(rst), .i_en(en),
    .i_sela(sela), .q_data(c_qd), .q_busya(c_ba),
    .i_selb(selb), .q_datb(c_qb), .q_busyb(c_bb),
    .i_we(we), .i_seld(seld), .i_datd(d),
    .i_we2(we2), .i_seld2(seld2), .i_datd2(d2),
    .i_claim(claim), .i_selc(selc));

  // ---------------- behavioural model ----------------
  int          cfg_n   [3] = '{8, 8, 6};
  bit          cfg_byp [3] = '{1'b1, 1'b0, 1'b1};
  int          cfg_sp  [3] = '{6, 6, 4};
  int          cfg_bp  [3] = '{7, 7, 5};
  logic [31:0] cfg_msk [3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
  logic [31:0] cfg_rst [3] = '{32'h0000_00FF, 32'h0000_00FF, 32'h0000_FFFF};

  logic [31:0] m_r  [3][8];
  bit          m_b  [3][8];
  logic [31:0] m_qd [3][2];
  bit          m_qb [3][2];
  bit          mvalid = 1'b0;

  task automatic model_step();
    logic [31:0] old_r [8];
    bit          old_b [8];
    int          s;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          m_r[k][i] = 32'h0;
          m_b[k][i] = 1'b0;
        end
        m_r[k][cfg_sp[k]] = cfg_rst[k];
        m_r[k][cfg_bp[k]] = cfg_rst[k];
        for (int p = 0; p < 2; p++) begin
          m_qd[k][p] = 32'h0;
          m_qb[k][p] = 1'b0;
        end
        mvalid = 1'b1;
      end else if (en && mvalid) begin
        old_r = m_r[k];
        old_b = m_b[k];
        if (we2 && int'(seld2) < cfg_n[k]) begin
          m_r[k][seld2] = d2 & cfg_msk[k];
          m_b[k][seld2] = 1'b0;
        end
        if (we && int'(seld) < cfg_n[k]) begin
          m_r[k][seld] = d & cfg_msk[k];
          m_b[k][seld] = 1'b0;
        end
        if (claim && int'(selc) < cfg_n[k]) m_b[k][selc] = 1'b1;
        for (int p = 0; p < 2; p++) begin
          s = (p == 0) ? int'(sela) : int'(selb);
          if (s >= cfg_n[k]) begin
            m_qd[k][p] = 32'h0;
            m_qb[k][p] = 1'b0;
          end else begin
            m_qd[k][p] = cfg_byp[k] ? m_r[k][s] : old_r[s];
            m_qb[k][p] = cfg_byp[k] ? m_b[k][s] : old_b[s];
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] act_d [3][2];
  bit          act_b [3][2];
  always_comb begin
    act_d[0][0] = {16'h0, a_qd}; act_d[0][1] = {16'h0, a_qb};
    act_d[1][0] = {16'h0, b_qd}; act_d[1][1] = {16'h0, b_qb};
    act_d[2][0] = c_qd;          act_d[2][1] = c_qb;
    act_b[0][0] = a_ba; act_b[0][1] = a_bb;
    act_b[1][0] = b_ba; act_b[1][1] = b_bb;
    act_b[2][0] = c_ba; act_b[2][1] = c_bb;
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < 2; p++) begin
          check($sformatf("model_dut%0d_data%0d", k, p), act_d[k][p], m_qd[k][p]);
          check($sformatf("model_dut%0d_busy%0d", k, p), {31'h0, act_b[k][p]}, {31'h0, m_qb[k][p]});
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; we = 1'b0; we2 = 1'b0; claim = 1'b0;
    sela = 3'd6; selb = 3'd0; seld = 3'd0; seld2 = 3'd0; selc = 3'd0;
    d = 32'h0; d2 = 32'h0;
    step();
    check("rst_qdata_zero", {16'h0, a_qd}, 32'h0);
    rst = 1'b0;
    step();
    check("rst_sp_a",    {16'h0, a_qd}, 32'h0000_00FF);
    check("rst_r0_b",    {16'h0, a_qb}, 32'h0);
    check("rst_busya",   {31'h0, a_ba}, 32'h0);
    check("rst_busyb",   {31'h0, a_bb}, 32'h0);
    check("c_sel6_oor",  c_qd, 32'h0);

    // reset with enable low
    we = 1'b1; seld = 3'd6; d = 32'h1234;
    step();
    check("sp_written", {16'h0, a_qd}, 32'h0000_1234);
    we = 1'b0; rst = 1'b1; en = 1'b0;
    step();
    check("rst_en0_q0", {16'h0, a_qd}, 32'h0);
    rst = 1'b0; en = 1'b1;
    step();
    check("rst_en0_sp", {16'h0, a_qd}, 32'h0000_00FF);

    // bypass vs read-first
    we = 1'b1; seld = 3'd3; d = 32'hBEEF; sela = 3'd3;
    step();
    check("byp1_beef", {16'h0, a_qd}, 32'h0000_BEEF);
    check("byp0_old",  {16'h0, b_qd}, 32'h0);
    we = 1'b0;
    step();
    check("byp0_beef", {16'h0, b_qd}, 32'h0000_BEEF);

    // write collision
    we = 1'b1; we2 = 1'b1; seld = 3'd2; seld2 = 3'd2; d = 32'h1111; d2 = 32'h2222; sela = 3'd0;
    step();
    we = 1'b0; we2 = 1'b0; sela = 3'd2;
    step();
    check("coll_a", {16'h0, a_qd}, 32'h0000_1111);
    check("coll_b", {16'h0, b_qd}, 32'h0000_1111);

    // scoreboard
    claim = 1'b1; selc = 3'd5; sela = 3'd5;
    step();
    check("claim_byp1", {31'h0, a_ba}, 32'h1);
    check("claim_byp0", {31'h0, b_ba}, 32'h0);
    claim = 1'b0;
    step();
    check("claim_byp0_late", {31'h0, b_ba}, 32'h1);
    we2 = 1'b1; seld2 = 3'd5; d2 = 32'h0042;
    step();
    check("wb_clear_busy", {31'h0, a_ba}, 32'h0);
    check("wb_data",       {16'h0, a_qd}, 32'h0000_0042);
    we2 = 1'b0; we = 1'b1; seld = 3'd5; d = 32'h0007; claim = 1'b1; selc = 3'd5;
    step();
    check("claim_wr_busy", {31'h0, a_ba}, 32'h1);
    check("claim_wr_data", {16'h0, a_qd}, 32'h0000_0007);
    we = 1'b0; claim = 1'b0;

    // enable freeze
    we = 1'b1; seld = 3'd1; d = 32'h00AA; sela = 3'd1;
    step();
    check("frz_wr", {16'h0, a_qd}, 32'h0000_00AA);
    en = 1'b0; d = 32'h5555; sela = 3'd0;
    step();
    check("frz_hold", {16'h0, a_qd}, 32'h0000_00AA);
    en = 1'b1; we = 1'b0; sela = 3'd1;
    step();
    check("frz_kept", {16'h0, a_qd}, 32'h0000_00AA);

    // parametric instance
    rst = 1'b1;
    step();
    rst = 1'b0; sela = 3'd4; selb = 3'd5;
    step();
    check("c_sp_rst", c_qd, 32'h0000_FFFF);
    check("c_bp_rst", c_qb, 32'h0000_FFFF);
    we = 1'b1; seld = 3'd7; d = 32'h1234_5678; claim = 1'b1; selc = 3'd7; sela = 3'd7; selb = 3'd6;
    step();
    check("c_oor_data", c_qd, 32'h0);
    check("c_oor_busy", {31'h0, c_ba}, 32'h0);
    we = 1'b0; claim = 1'b0;
    step();
    check("c_oor_data2", c_qd, 32'h0);
    we = 1'b1; seld = 3'd0; d = 32'hDEAD_BEEF; sela = 3'd0;
    step();
    check("c_wide", c_qd, 32'hDEAD_BEEF);
    check("a_trunc", {16'h0, a_qd}, 32'h0000_BEEF);
    we = 1'b0;

    // mixed traffic, checked by the per-cycle model compare
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom); we2 = 1'($urandom); claim = 1'($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 7) != 0);
      seld = 3'($urandom); seld2 = 3'($urandom); selc = 3'($urandom);
      sela = 3'($urandom); selb = 3'($urandom);
      d = $urandom; d2 = $urandom;
      step();
    end
    we = 1'b0; we2 = 1'b0; claim = 1'b0; en = 1'b1;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
